// File: rtl/led_burst_sequencer.sv
// Write-then-read-back burst self-test sequencer for the led AXI4 master engine.
// Writes BURST_LEN beats of SEED+i, reads them back, and reports mismatch statistics.
module led_burst_sequencer #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 8,
   parameter int SEED      = 1
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              resp_err,
   output logic [8:0]        err_cnt,
   output logic [7:0]        first_err_idx,
   output logic              eng_cmd_valid,
   input  logic              eng_cmd_ready,
   output logic              eng_cmd_wr,
   output logic [ADDR_W-1:0] eng_cmd_addr,
   output logic [7:0]        eng_cmd_len,
   output logic [DATA_W-1:0] eng_wdata,
   output logic              eng_wvalid,
   input  logic              eng_wready,
   output logic              eng_wlast,
   input  logic [DATA_W-1:0] eng_rdata,
   input  logic              eng_rvalid,
   input  logic              eng_done,
   input  logic [1:0]        eng_resp
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_CMD, S_WR_DATA, S_WR_WAIT, S_RD_CMD, S_RD_DATA, S_DONE
   } state_t;

   localparam logic [8:0]        LAST_BEAT = 9'(BURST_LEN - 1);
   localparam logic [9:0]        LEN10     = 10'(BURST_LEN);
   localparam logic [DATA_W-1:0] SEED_V    = DATA_W'(SEED);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        len_q, len_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [8:0]        wbeat_q, wbeat_d;
   logic [8:0]        rbeat_q, rbeat_d;
   logic              pass_q, pass_d;
   logic              resp_err_q, resp_err_d;
   logic [8:0]        err_cnt_q, err_cnt_d;
   logic [7:0]        first_q, first_d;

   logic [DATA_W-1:0] rd_exp;
   logic              beat_bad;
   logic [9:0]        err_sum1, err_sum2, rcnt_after, missing;
   logic [8:0]        err_beat, err_final;

   always_comb begin
      rd_exp     = SEED_V + DATA_W'(rbeat_q);
      // Beats past the programmed length are errors regardless of their data.
      beat_bad   = (rbeat_q > LAST_BEAT) || (eng_rdata != rd_exp);
      err_sum1   = {1'b0, err_cnt_q} + {9'd0, eng_rvalid & beat_bad};
      err_beat   = err_sum1[9] ? 9'h1FF : err_sum1[8:0];
      rcnt_after = {1'b0, rbeat_q} + {9'd0, eng_rvalid};
      missing    = (rcnt_after < LEN10) ? (LEN10 - rcnt_after) : 10'd0;
      err_sum2   = {1'b0, err_beat} + missing;
      err_final  = err_sum2[9] ? 9'h1FF : err_sum2[8:0];
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      wdata_d    = wdata_q;
      wbeat_d    = wbeat_q;
      rbeat_d    = rbeat_q;
      pass_d     = pass_q;
      resp_err_d = resp_err_q;
      err_cnt_d  = err_cnt_q;
      first_d    = first_q;
      unique case (state_q)
         S_IDLE: if (start) begin
            addr_d     = base_addr;
            len_d      = 8'(BURST_LEN - 1);
            pass_d     = 1'b0;
            resp_err_d = 1'b0;
            err_cnt_d  = '0;
            first_d    = '0;
            state_d    = S_WR_CMD;
         end
         S_WR_CMD: if (eng_cmd_ready) begin
            wbeat_d = '0;
            wdata_d = SEED_V;
            state_d = S_WR_DATA;
         end
         S_WR_DATA: if (eng_wready) begin
            if (wbeat_q == LAST_BEAT) begin
               state_d = S_WR_WAIT;
            end else begin
               wbeat_d = wbeat_q + 9'd1;
               wdata_d = wdata_q + DATA_W'(1);
            end
         end
         S_WR_WAIT: if (eng_done) begin
            if (eng_resp != 2'b00) begin
               resp_err_d = 1'b1;
               state_d    = S_DONE;
            end else begin
               state_d = S_RD_CMD;
            end
         end
         S_RD_CMD: if (eng_cmd_ready) begin
            rbeat_d = '0;
            state_d = S_RD_DATA;
         end
         S_RD_DATA: begin
            if (eng_rvalid) begin
               err_cnt_d = err_beat;
               if (beat_bad && err_cnt_q == 9'd0) first_d = rbeat_q[7:0];
               if (rbeat_q != 9'h1FF) rbeat_d = rbeat_q + 9'd1;
            end
            // A beat arriving with eng_done is already folded into err_final.
            if (eng_done) begin
               err_cnt_d  = err_final;
               resp_err_d = resp_err_q | (eng_resp != 2'b00);
               pass_d     = (err_final == 9'd0) && (eng_resp == 2'b00) && !resp_err_q;
               state_d    = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         wdata_q    <= '0;
         wbeat_q    <= '0;
         rbeat_q    <= '0;
         pass_q     <= 1'b0;
         resp_err_q <= 1'b0;
         err_cnt_q  <= '0;
         first_q    <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         wdata_q    <= wdata_d;
         wbeat_q    <= wbeat_d;
         rbeat_q    <= rbeat_d;
         pass_q     <= pass_d;
         resp_err_q <= resp_err_d;
         err_cnt_q  <= err_cnt_d;
         first_q    <= first_d;
      end
   end

   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign pass          = pass_q;
   assign resp_err      = resp_err_q;
   assign err_cnt       = err_cnt_q;
   assign first_err_idx = first_q;
   assign eng_cmd_valid = (state_q == S_WR_CMD) || (state_q == S_RD_CMD);
   assign eng_cmd_wr    = (state_q == S_WR_CMD);
   assign eng_cmd_addr  = addr_q;
   assign eng_cmd_len   = len_q;
   assign eng_wdata     = wdata_q;
   assign eng_wvalid    = (state_q == S_WR_DATA);
   assign eng_wlast     = (state_q == S_WR_DATA) && (wbeat_q == LAST_BEAT);

endmodule

// File: tb/tb_led_burst_sequencer.sv
// Directed bench for led_burst_sequencer: the engine is played cycle by cycle from one
// initial block, driving on the falling edge and sampling DUT outputs there.
module tb_led_burst_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] base_addr;
   logic        busy, done, pass, resp_err;
   logic [8:0]  err_cnt;
   logic [7:0]  first_err_idx;
   logic        cmd_valid, cmd_ready, cmd_wr;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [31:0] wdata;
   logic        wvalid, wready, wlast;
   logic [31:0] rdata;
   logic        rvalid, eng_done;
   logic [1:0]  eng_resp;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   led_burst_sequencer dut (
      .ACLK(clk), .ARESET(rst), .start(start), .base_addr(base_addr),
      .busy(busy), .done(done), .pass(pass), .resp_err(resp_err),
      .err_cnt(err_cnt), .first_err_idx(first_err_idx),
      .eng_cmd_valid(cmd_valid), .eng_cmd_ready(cmd_ready), .eng_cmd_wr(cmd_wr),
      .eng_cmd_addr(cmd_addr), .eng_cmd_len(cmd_len),
      .eng_wdata(wdata), .eng_wvalid(wvalid), .eng_wready(wready), .eng_wlast(wlast),
      .eng_rdata(rdata), .eng_rvalid(rvalid), .eng_done(eng_done), .eng_resp(eng_resp)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_resp_err"}, resp_err, 0);
      chk({tag, "_err_cnt"}, err_cnt, 0);
      chk({tag, "_first"}, first_err_idx, 0);
      chk({tag, "_cmd_valid"}, cmd_valid, 0);
      chk({tag, "_cmd_wr"}, cmd_wr, 0);
      chk({tag, "_cmd_addr"}, cmd_addr, 0);
      chk({tag, "_cmd_len"}, cmd_len, 0);
      chk({tag, "_wdata"}, wdata, 0);
      chk({tag, "_wvalid"}, wvalid, 0);
      chk({tag, "_wlast"}, wlast, 0);
   endtask

   // One complete run: start, command/write phase, write response, optional read phase.
   task automatic run(input logic [31:0] base, input int cmd_hold, input bit wrand,
                      input bit poke, input logic [1:0] wr_resp, input int bad_idx,
                      input int rd_beats, input bit exp_pass, input int exp_err,
                      input bit exp_rerr, input int exp_first);
      int e;
      int cyc;
      @(negedge clk); start = 1'b1; base_addr = base;
      @(negedge clk); start = 1'b0;
      chk("start_busy", busy, 1);
      chk("wr_cmd_valid", cmd_valid, 1);
      chk("wr_cmd_wr", cmd_wr, 1);
      chk("wr_cmd_addr", cmd_addr, base);
      chk("wr_cmd_len", cmd_len, 7);
      for (int h = 0; h < cmd_hold; h++) begin
         if (poke) begin start = 1'b1; base_addr = base ^ 32'h0000_FFFF; end
         @(negedge clk); start = 1'b0;
         chk("hold_valid", cmd_valid, 1);
         chk("hold_wr", cmd_wr, 1);
         chk("hold_addr", cmd_addr, base);
         chk("hold_len", cmd_len, 7);
      end
      cmd_ready = 1'b1;
      @(negedge clk); cmd_ready = 1'b0;
      e = 0; cyc = 0;
      while (e < 8 && cyc < 200) begin
         chk("wvalid", wvalid, 1);
         chk("wdata", wdata, 32'(1 + e));
         chk("wlast", wlast, (e == 7));
         wready = wrand ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (wready) e++;
         cyc++;
      end
      wready = 1'b0;
      if (e < 8) chk("wr_timeout", e, 8);
      chk("wvalid_end", wvalid, 0);
      eng_done = 1'b1; eng_resp = wr_resp;
      @(negedge clk); eng_done = 1'b0; eng_resp = 2'b00;
      if (wr_resp != 2'b00) begin
         chk("wresp_no_read", cmd_valid, 0);
      end else begin
         chk("rd_cmd_valid", cmd_valid, 1);
         chk("rd_cmd_wr", cmd_wr, 0);
         chk("rd_cmd_addr", cmd_addr, base);
         cmd_ready = 1'b1;
         @(negedge clk); cmd_ready = 1'b0;
         for (int i = 0; i < rd_beats; i++) begin
            rvalid = 1'b1;
            rdata  = (i == bad_idx) ? 32'hDEAD : 32'(1 + i);
            if (i == rd_beats - 1) eng_done = 1'b1;
            @(negedge clk);
         end
         rvalid = 1'b0; eng_done = 1'b0;
      end
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 1);
      chk("pass", pass, exp_pass);
      chk("err_cnt", err_cnt, exp_err);
      chk("resp_err", resp_err, exp_rerr);
      if (exp_first >= 0) chk("first_err_idx", first_err_idx, exp_first);
      @(negedge clk);
      chk("post_busy", busy, 0);
      chk("post_done", done, 0);
      chk("pass_held", pass, exp_pass);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0;
      cmd_ready = 1'b0; wready = 1'b0; rdata = '0; rvalid = 1'b0;
      eng_done = 1'b0; eng_resp = 2'b00;
      #1 chk_idle_outputs("reset");
      @(negedge clk); @(negedge clk); rst = 1'b0;

      // Ideal memory
      run(32'h0, 0, 0, 0, 2'b00, -1, 8, 1, 0, 0, -1);
      // Corrupted read beat 3
      run(32'h0, 0, 0, 0, 2'b00, 3, 8, 0, 1, 0, 3);
      // Write response SLVERR: no read
      run(32'h0, 0, 0, 0, 2'b10, -1, 0, 0, 0, 1, -1);
      // Command backpressure, random wready, start re-pulsed while busy
      run(32'h1000, 5, 1, 1, 2'b00, -1, 8, 1, 0, 0, -1);
      // Read terminated after 6 beats
      run(32'h0, 0, 0, 0, 2'b00, -1, 6, 0, 2, 0, -1);

      // Abort with reset in the middle of the write burst
      @(negedge clk); start = 1'b1; base_addr = 32'h40;
      @(negedge clk); start = 1'b0; cmd_ready = 1'b1;
      @(negedge clk); cmd_ready = 1'b0; wready = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("mid_wdata", wdata, 3);
      wready = 1'b0;
      rst = 1'b1;
      #1 chk_idle_outputs("abort");
      @(negedge clk); rst = 1'b0;
      chk("abort_still_idle", busy, 0);
      run(32'h80, 0, 0, 0, 2'b00, -1, 8, 1, 0, 0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/led_burst_sequencer.md
# led_burst_sequencer

Hardware sequencer for the led AXI4 full-master burst engine. One `start` pulse runs a self-checking write-then-read-back burst at a programmable base address: write `BURST_LEN` beats of an incrementing pattern, read the same region back, compare beat by beat, then report pass/fail and error statistics. It sits between the register/control side and the command/data interface of the AXI4 master engine.

## Interface
- `ADDR_W`, 32, width of the engine command address.
- `DATA_W`, 32, data beat width.
- `BURST_LEN`, 8, beats per burst (1..256); `eng_cmd_len` = `BURST_LEN`-1.
- `SEED`, 1, pattern value of beat 0; beat i = (`SEED`+i) mod 2^`DATA_W`.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `ACLK`  in  1  clock; all logic on the rising edge.
- `ARESET`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  `ADDR_W`  burst base address; captured on accepted `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of a run.
- `pass`  out  1  result of the last run; valid from `done`, held until the next accepted `start`.
- `resp_err`  out  1  the engine returned a non-OKAY response in the last run.
- `err_cnt`  out  9  mismatching or missing beats in the last run; saturates at 511.
- `first_err_idx`  out  8  index of the first mismatching beat; meaningful only when `err_cnt`≠0.
- `eng_cmd_valid`  out  1 / `eng_cmd_ready`  in  1  command handshake.
- `eng_cmd_wr`  out  1  1 = write burst, 0 = read burst.
- `eng_cmd_addr`  out  `ADDR_W` / `eng_cmd_len`  out  8  burst address and length.
- `eng_wdata`  out  `DATA_W` / `eng_wvalid`  out  1 / `eng_wready`  in  1 / `eng_wlast`  out  1  write beat stream.
- `eng_rdata`  in  `DATA_W` / `eng_rvalid`  in  1  read beat stream; the sequencer is always ready.
- `eng_done`  in  1 / `eng_resp`  in  2  burst-complete pulse and response (00 = OKAY).

## Operation
- States: IDLE, WR_CMD, WR_DATA, WR_WAIT, RD_CMD, RD_DATA, DONE.
- IDLE: accepting `start` captures `base_addr`, clears `pass`, `resp_err`, `err_cnt` and `first_err_idx`, then enters WR_CMD. `start` in any other state is ignored.
- WR_CMD: `eng_cmd_valid`=1, `eng_cmd_wr`=1. On handshake, go to WR_DATA with write beat counter = 0.
- WR_DATA: `eng_wvalid`=1, `eng_wdata`=`SEED`+beat, `eng_wlast`=1 only when beat=`BURST_LEN`-1. The counter advances on `eng_wvalid`&`eng_wready`. The last handshake goes to WR_WAIT.
- WR_WAIT: on `eng_done`:
  - `eng_resp`≠00: set `resp_err`, go to DONE; no read is issued.
  - `eng_resp`=00: go to RD_CMD.
- RD_CMD: same as WR_CMD with `eng_cmd_wr`=0. On handshake, go to RD_DATA with read beat counter = 0.
- RD_DATA, each `eng_rvalid` beat:
  - compare against `SEED`+index; increment the counter.
  - on mismatch, increment `err_cnt`; on the first mismatch, record `first_err_idx`.
  - beats with index ≥`BURST_LEN` count as errors.
- RD_DATA, on `eng_done`:
  - beats missing (fewer than `BURST_LEN` received) are added to `err_cnt`.
  - `eng_resp`≠00 sets `resp_err`.
  - go to DONE.
- If `eng_rvalid` and `eng_done` are high in the same cycle, the beat is counted before the completion check.
- DONE: `done`=1, `pass` = (`err_cnt`=0 after final update) & !`resp_err`; return to IDLE next cycle.
- `eng_done` outside WR_WAIT/RD_DATA is ignored.
- Pattern arithmetic is modulo 2^`DATA_W` (wraps).

## Timing
- Reset values: state IDLE; `busy`, `done`, `pass`, `resp_err`, `eng_cmd_valid`, `eng_cmd_wr`, `eng_wvalid`, `eng_wlast` = 0; `err_cnt`, `first_err_idx`, `eng_cmd_addr`, `eng_cmd_len`, `eng_wdata` = 0. All are applied immediately on `ARESET`.
- `ARESET` mid-run aborts without completing handshakes. The engine shares the same reset.
- `start` at edge N → `eng_cmd_valid`=1 and `busy`=1 in cycle N+1.
- Command and write-data outputs are registered. `eng_cmd_*` stay stable while `eng_cmd_valid`&!`eng_cmd_ready`. `eng_wdata`/`eng_wlast` stay stable while `eng_wvalid`&!`eng_wready`.
- Write phase: a beat issues every cycle when `eng_wready`=1 continuously, giving `BURST_LEN` cycles.
- Read compare needs zero bubbles: one beat per cycle is accepted.
- `done` is asserted one cycle after the final `eng_done`; `busy` drops the cycle after `done`.

## Test plan
- Ideal memory model, `base_addr`=0, defaults → writes 1..8, reads 1..8, `done` pulse, `pass`=1, `err_cnt`=0, `resp_err`=0.
- Model returns 0xDEAD on read beat 3 → `pass`=0, `err_cnt`=1, `first_err_idx`=3.
- Write `eng_resp`=2'b10 → no read command issued; `done` pulse, `pass`=0, `resp_err`=1, `err_cnt`=0.
- Hold `eng_cmd_ready` low 5 cycles and toggle `eng_wready` randomly → command fields stable, `eng_wdata` sequence 1..8 with no skips or repeats, `eng_wlast` only on 8.
- Read `eng_done` after 6 beats → `pass`=0, `err_cnt`=2.
- `start` re-pulsed while busy → ignored. `ARESET` in WR_DATA → all outputs at reset values the same cycle; a new `start` then runs clean, `pass`=1.
